// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line levels,
// common to uart_tx and the future uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// A one-entry holding register lets the next frame start right after the last stop bit.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 frame_done
);

  import uart_pkg::*;

  localparam int                CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = (STOP_BITS > 1);
  localparam logic              ODD_BIT   = (PARITY_ODD != 0);

  uart_tx_state_e       state;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 hold_valid;
  logic                 hold_valid_next;
  logic                 parity_bit;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 accept;
  logic                 reload;

  assign accept  = tx_valid && tx_ready;
  // The hold register empties into the shifter on a tick in IDLE or at the end of the last stop bit.
  assign reload  = baud_tick && hold_valid &&
                   ((state == IDLE) || ((state == STOP) && (stop_cnt == LAST_STOP)));
  assign tx_busy = (state != IDLE);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hold_valid_next = hold_valid;
    if (accept) begin
      hold_valid_next = 1'b1;
    end else if (reload) begin
      hold_valid_next = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; data registers are reset as
  // well so that nothing downstream ever observes X after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      tx_ready   <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= tx_data;
      end
      hold_valid <= hold_valid_next;
      tx_ready   <= ~hold_valid_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= UART_IDLE_LEVEL;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (baud_tick) begin
        unique case (state)
          IDLE: begin
            if (reload) begin
              shift_reg  <= hold_data;
              parity_bit <= (^hold_data) ^ ODD_BIT;
              tx         <= UART_START_LEVEL;
              state      <= START;
            end
          end
          START: begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= '0;
            state     <= DATA;
          end
          DATA: begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx       <= UART_IDLE_LEVEL;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            tx       <= UART_IDLE_LEVEL;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
          STOP: begin
            if (stop_cnt == LAST_STOP) begin
              frame_done <= 1'b1;
              // A waiting byte starts immediately so back-to-back frames have no idle gap.
              if (reload) begin
                shift_reg  <= hold_data;
                parity_bit <= (^hold_data) ^ ODD_BIT;
                tx         <= UART_START_LEVEL;
                state      <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: begin
            tx    <= UART_IDLE_LEVEL;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) share clock, reset and baud tick.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic [3:0] tx_valid;
  logic [3:0] tx_ready;
  logic [3:0] tx;
  logic [3:0] tx_busy;
  logic [3:0] frame_done;

  int checks = 0;
  int errors = 0;
  int tick_cnt;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx(tx[0]),
    .tx_busy(tx_busy[0]), .frame_done(frame_done[0]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx(tx[1]),
    .tx_busy(tx_busy[1]), .frame_done(frame_done[1]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .tx(tx[2]),
    .tx_busy(tx_busy[2]), .frame_done(frame_done[2]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]), .tx(tx[3]),
    .tx_busy(tx_busy[3]), .frame_done(frame_done[3]));

  // Free-running 1x baud tick, one pulse every 16 clocks, also during reset.
  initial begin
    baud_tick = 1'b0;
    tick_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      tick_cnt  = (tick_cnt == 15) ? 0 : tick_cnt + 1;
      baud_tick = (tick_cnt == 15);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Offer one byte on instance k and wait for acceptance; keep leaves tx_valid high afterwards.
  task automatic send(input int k, input logic [7:0] data, input bit keep, input string name);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    tx_data     = data;
    tx_valid[k] = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tx_ready[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) tx_valid[k] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept: tx_ready stayed %b, required 1 within 600 clks", name, tx_ready[k]);
    end
  endtask

  // Follow instance k from the falling start edge: each expected bit level must hold 16 clks
  // with tx_busy high, frame_done must pulse right after the last bit, and the line must idle.
  task automatic capture(input int k, input logic [19:0] bits, input int nbits,
                         input int pulses, input string name);
    bit   found = 1'b0;
    int   bad;
    int   fd_cnt = 0;
    logic last_tx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx[k] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s start: tx stayed %b for 100 clks, required 0", name, tx[k]);
      return;
    end
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      last_tx = bits[b];
      for (int s = 0; s < 16; s++) begin
        if (b != 0 || s != 0) @(negedge clk);
        if (tx[k] !== bits[b] || tx_busy[k] !== 1'b1) begin
          bad++;
          last_tx = tx[k];
        end
        if (frame_done[k] === 1'b1) fd_cnt++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit %0d: tx %b (busy %b) on %0d of 16 clks, required tx %b busy 1",
                 name, b, last_tx, tx_busy[k], bad, bits[b]);
      end
    end
    @(negedge clk);
    if (frame_done[k] === 1'b1) fd_cnt++;
    checks++;
    if (frame_done[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_done timing: got %b after last bit, required 1", name, frame_done[k]);
    end
    repeat (16) begin
      @(negedge clk);
      if (frame_done[k] === 1'b1) fd_cnt++;
    end
    checks++;
    if (fd_cnt != pulses) begin
      errors++;
      $display("FAIL %s frame_done count: got %0d, required %0d", name, fd_cnt, pulses);
    end
    checks++;
    if (tx[k] !== 1'b1 || tx_busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s idle after frame: tx %b busy %b, required tx 1 busy 0", name, tx[k], tx_busy[k]);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    tx_valid = '0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 4'hF) begin
      errors++;
      $display("FAIL reset tx: got %b, required 1111", tx);
    end
    checks++;
    if (tx_busy !== 4'h0) begin
      errors++;
      $display("FAIL reset tx_busy: got %b, required 0000", tx_busy);
    end
    checks++;
    if (frame_done !== 4'h0) begin
      errors++;
      $display("FAIL reset frame_done: got %b, required 0000", frame_done);
    end
    checks++;
    if (tx_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset tx_ready: got %b, required 0000", tx_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 4'h0) begin
      errors++;
      $display("FAIL release tx_ready early: got %b, required 0000", tx_ready);
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 4'hF) begin
      errors++;
      $display("FAIL release tx_ready: got %b one clk after release, required 1111", tx_ready);
    end
  endtask

  task automatic test_8n1();
    send(0, 8'hA5, 1'b0, "8n1");
    capture(0, 20'(10'b1101001010), 10, 1, "8n1 0xA5");
  endtask

  task automatic test_parity();
    send(1, 8'h07, 1'b0, "even");
    capture(1, 20'(11'b11000001110), 11, 1, "even parity 0x07");
    send(2, 8'h07, 1'b0, "odd");
    capture(2, 20'(11'b10000001110), 11, 1, "odd parity 0x07");
  endtask

  task automatic test_back_to_back();
    fork
      capture(0, 20'b1101010100_1010101010, 20, 2, "b2b 0x55 0xAA");
      begin
        send(0, 8'h55, 1'b1, "b2b first");
        tx_data = 8'hAA;
        @(negedge clk);
        checks++;
        if (tx_ready[0] !== 1'b0) begin
          errors++;
          $display("FAIL b2b ready drop: got %b with hold full, required 0", tx_ready[0]);
        end
        send(0, 8'hAA, 1'b0, "b2b second");
        @(negedge clk);
        checks++;
        if (tx_ready[0] !== 1'b0) begin
          errors++;
          $display("FAIL b2b ready refill: got %b after second accept, required 0", tx_ready[0]);
        end
      end
    join
  endtask

  task automatic test_two_stop();
    send(3, 8'h00, 1'b0, "8n2");
    capture(3, 20'(11'b11000000000), 11, 1, "8n2 0x00");
  endtask

  task automatic test_tick_accept();
    bit found = 1'b0;
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (baud_tick === 1'b1 && tx_ready[0] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tick accept align: no ready tick within 40 clks, required one");
      return;
    end
    tx_data     = 8'h3C;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (tx[0] === 1'b0) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL tick accept latency: tx fell on clk %0d after accept, required 17", n);
    end
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_busy[0] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || tx[0] !== 1'b1) begin
      errors++;
      $display("FAIL tick accept frame end: busy %b tx %b, required busy 0 tx 1", tx_busy[0], tx[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found = 1'b0;
    int bad = 0;
    send(0, 8'h00, 1'b0, "reset frame");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx[0] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset frame start: tx stayed %b, required 0", tx[0]);
      return;
    end
    // Sample 1 of the start bit seen; sample 72 sits mid data bit 3.
    repeat (71) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0 || tx_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset pre data bit 3: tx %b busy %b, required tx 0 busy 1", tx[0], tx_busy[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || tx_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset abort: tx %b busy %b, required tx 1 busy 0", tx[0], tx_busy[0]);
    end
    checks++;
    if (tx_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset abort tx_ready: got %b, required 0", tx_ready[0]);
    end
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (tx_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset release tx_ready early: got %b, required 0", tx_ready[0]);
    end
    @(negedge clk);
    checks++;
    if (tx_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset release tx_ready: got %b, required 1", tx_ready[0]);
    end
    repeat (200) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || tx_busy[0] !== 1'b0 || frame_done[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset residual frame: %0d of 200 clks not idle, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_two_stop();
    test_tick_accept();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
